// File: rtl/host_uart_comm_pkg.sv
// Shared types and constants for the host-side UART command endpoint.
package host_comm_pkg;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  localparam int CMD_BYTES = 3;
  localparam int CMD_W     = 8 * CMD_BYTES;

endpackage

// File: rtl/host_uart_comm_if.sv
// Command/response handshake between the UART endpoint (slave) and dig_core (master).
interface host_uart_comm_if;
  import host_comm_pkg::*;

  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic [7:0]       resp_data;
  logic             send_resp;
  logic             resp_sent;

  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp_data, send_resp
  );

  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp_data, send_resp
  );

endinterface

// File: rtl/host_uart_comm_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling FSM, framing check.
module uart_rx_byte
  import host_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_idle_o
);

  localparam int            TW        = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(BAUD_DIV / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_prev_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:      if (rx_prev_q && !rx_s) state_d = RX_START;
      RX_START:     if (cnt_q == HALF_LAST) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (cnt_q == BIT_LAST && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:      if (cnt_q == BIT_LAST) state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
      default:      state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d = '0;
        bit_d = '0;
      end
      RX_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        shreg_d = {rx_s, shreg_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      RX_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        valid_d = rx_s;
        ferr_d  = !rx_s;
      end
      default: cnt_d = '0;
    endcase
  end

  assign rx_byte_o  = shreg_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;
  assign rx_idle_o  = (state_q == RX_IDLE);

endmodule

// File: rtl/host_uart_comm.sv
// Host serial endpoint: assembles 3-byte commands from RX, serialises response bytes on TX.
module host_uart_comm
  import host_comm_pkg::*;
#(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  output logic             TX,
  host_uart_comm_if.slave  hif
);

  localparam int             TW        = $clog2(BAUD_DIV);
  localparam logic [TW-1:0]  BIT_LAST  = TW'(BAUD_DIV - 1);
  localparam int             TMO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int             TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);
  localparam logic [1:0]     BCNT_LAST = 2'(CMD_BYTES - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, rx_idle;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (RX),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr),
    .rx_idle_o  (rx_idle)
  );

  // ---------------- command assembly ----------------
  logic [1:0]       bcnt_q, bcnt_d;
  logic [CMD_W-1:0] shadow_q, shadow_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q    <= '0;
      shadow_q  <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      bcnt_q    <= bcnt_d;
      shadow_q  <= shadow_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      tmo_q     <= tmo_d;
    end
  end

  // Timer only runs while a partial command sits waiting on an idle line.
  assign tmo_fire = (bcnt_q != 2'd0) && rx_idle && !rx_valid && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (bcnt_q == 2'd0 || !rx_idle || rx_valid || tmo_fire) tmo_d = '0;
  end

  always_comb begin
    bcnt_d    = bcnt_q;
    shadow_d  = shadow_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (hif.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (rx_valid) begin
      case (bcnt_q)
        2'd0: begin shadow_d[23:16] = rx_byte; bcnt_d = 2'd1; end
        2'd1: begin shadow_d[15:8]  = rx_byte; bcnt_d = 2'd2; end
        default: begin
          shadow_d[7:0] = rx_byte;
          bcnt_d        = '0;
        end
      endcase
      // Completion overrides a coincident acknowledge.
      if (bcnt_q == BCNT_LAST) begin
        cmd_d     = {shadow_q[23:8], rx_byte};
        cmd_rdy_d = 1'b1;
      end
    end else if (rx_ferr || tmo_fire) begin
      bcnt_d = '0;
    end
  end

  assign hif.cmd     = cmd_q;
  assign hif.cmd_rdy = cmd_rdy_q;

  // ---------------- TX FSM ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [TW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (hif.send_resp) tx_state_d = TX_START;
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_state_d = hif.send_resp ? TX_START : TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    case (tx_state_q)
      TX_IDLE:  tx_cnt_d = '0;
      TX_START: if (tx_bit_end) begin tx_cnt_d = '0; tx_bit_d = '0; end
      TX_DATA:  if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
      end
      default:  if (tx_bit_end) tx_cnt_d = '0;
    endcase
    if (tx_state_d == TX_START && (tx_state_q == TX_IDLE || tx_state_q == TX_STOP)) begin
      tx_sh_d  = hif.resp_data;
      tx_cnt_d = '0;
    end
  end

  always_comb begin
    TX            = 1'b1;
    hif.resp_sent = 1'b0;
    case (tx_state_q)
      TX_START: TX = 1'b0;
      TX_DATA:  TX = tx_sh_q[0];
      TX_STOP:  hif.resp_sent = tx_bit_end;
      default:  TX = 1'b1;
    endcase
  end

endmodule
